// File: rtl/arith_mon_pkg.sv
// arith_mon shared definitions: op encodings and the reference model.
// The model works at MAX_W bits; callers keep the low WIDTH bits.
package arith_mon_pkg;

   localparam int MAX_W = 64;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_XOR = 2'd3;

   // Injection forces the expected value to b so a correct DUT
   // still produces mismatches on roughly a quarter of random data.
   function automatic logic [MAX_W-1:0] ref_calc(
      input logic [1:0]       op,
      input logic [MAX_W-1:0] a,
      input logic [MAX_W-1:0] b,
      input logic             inj
   );
      logic [MAX_W-1:0] r;
      r = '0;
      if (inj && a[0] && b[0]) begin
         r = b;
      end else begin
         unique case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/arith_mon_delay.sv
// arith_mon_delay: fixed-length shift register, async reset.
// Carries {valid, expected} so the tail lines up with the DUT output.
module arith_mon_delay #(
   parameter int W       = 33,
   parameter int LATENCY = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stg [LATENCY];

   // Shift every cycle; bubbles travel down the line too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[LATENCY-1];

endmodule

// File: rtl/arith_mon.sv
// arith_mon: delayed reference model compared against the DUT
// output, with saturating transaction/error counters.
module arith_mon
   import arith_mon_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_inj_en,
   input  logic             i_dut_valid,
   input  logic [WIDTH-1:0] i_dut_o,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_mon_o,
   output logic [WIDTH-1:0] o_dtm_o,
   output logic             o_cmp_valid,
   output logic             o_mismatch,
   output logic             o_missing,
   output logic             o_spurious,
   output logic [CNT_W-1:0] o_txn_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_sticky_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [MAX_W-1:0] mdl_full;
   logic             unused_mdl;
   logic [WIDTH:0]   head;
   logic [WIDTH:0]   tail;
   logic             ev;
   logic [WIDTH-1:0] exp_d;
   logic             cmp_nxt;
   logic             mis_nxt;

   assign mdl_full = ref_calc(i_op, MAX_W'(i_a), MAX_W'(i_b), i_inj_en);
   assign unused_mdl = ^mdl_full;
   assign head = {i_valid, mdl_full[WIDTH-1:0]};

   arith_mon_delay #(
      .W       (WIDTH + 1),
      .LATENCY (LATENCY)
   ) u_delay (
      .clk   (clk),
      .reset (reset),
      .d     (head),
      .q     (tail)
   );

   assign ev      = tail[WIDTH];
   assign exp_d   = tail[WIDTH-1:0];
   assign cmp_nxt = ev | i_dut_valid;
   assign mis_nxt = (ev & i_dut_valid) ? (exp_d != i_dut_o) : cmp_nxt;

   // Registered compare stage; data outputs hold when their side is idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_cmp_valid <= 1'b0;
         o_mismatch  <= 1'b0;
         o_missing   <= 1'b0;
         o_spurious  <= 1'b0;
         o_mon_o     <= '0;
         o_dtm_o     <= '0;
      end else begin
         o_cmp_valid <= cmp_nxt;
         o_mismatch  <= mis_nxt;
         o_missing   <= ev & ~i_dut_valid;
         o_spurious  <= i_dut_valid & ~ev;
         if (ev) o_mon_o <= exp_d;
         if (i_dut_valid) o_dtm_o <= i_dut_o;
      end
   end

   // Statistics update on the same edge as the compare flags;
   // a clear in that cycle drops the event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_txn_cnt    <= '0;
         o_err_cnt    <= '0;
         o_sticky_err <= 1'b0;
      end else if (i_clr) begin
         o_txn_cnt    <= '0;
         o_err_cnt    <= '0;
         o_sticky_err <= 1'b0;
      end else begin
         if (cmp_nxt && o_txn_cnt != CNT_MAX)
            o_txn_cnt <= o_txn_cnt + CNT_W'(1);
         if (mis_nxt && o_err_cnt != CNT_MAX)
            o_err_cnt <= o_err_cnt + CNT_W'(1);
         if (mis_nxt)
            o_sticky_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arith_mon.sv
// tb_arith_mon: scoreboard bench for arith_mon.
// Stimulus pushes expected compares; a negedge monitor pops them.
module tb_arith_mon;

   localparam int W    = 32;
   localparam int LAT  = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic          i_valid;
   logic [1:0]    i_op;
   logic [W-1:0]  i_a;
   logic [W-1:0]  i_b;
   logic          i_inj_en;
   logic          i_dut_valid;
   logic [W-1:0]  i_dut_o;
   logic          i_clr;
   logic [W-1:0]  o_mon_o;
   logic [W-1:0]  o_dtm_o;
   logic          o_cmp_valid;
   logic          o_mismatch;
   logic          o_missing;
   logic          o_spurious;
   logic [CW-1:0] o_txn_cnt;
   logic [CW-1:0] o_err_cnt;
   logic          o_sticky_err;

   arith_mon #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_valid      (i_valid),
      .i_op         (i_op),
      .i_a          (i_a),
      .i_b          (i_b),
      .i_inj_en     (i_inj_en),
      .i_dut_valid  (i_dut_valid),
      .i_dut_o      (i_dut_o),
      .i_clr        (i_clr),
      .o_mon_o      (o_mon_o),
      .o_dtm_o      (o_dtm_o),
      .o_cmp_valid  (o_cmp_valid),
      .o_mismatch   (o_mismatch),
      .o_missing    (o_missing),
      .o_spurious   (o_spurious),
      .o_txn_cnt    (o_txn_cnt),
      .o_err_cnt    (o_err_cnt),
      .o_sticky_err (o_sticky_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic         mis;
      logic         miss;
      logic         spur;
      logic [W-1:0] mon;
      logic [W-1:0] dtm;
   } ent_t;

   ent_t         sbq[$];
   logic [W:0]   sched[int];
   logic [W:0]   plan[int];
   int           cyc;
   int           n_chk;
   int           n_fail;
   int           m_txn;
   int           m_err;
   logic         m_sticky;
   logic [W-1:0] m_mon;
   logic [W-1:0] m_dtm;
   bit           running;
   logic         mon_ev;
   ent_t         mon_en;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   function automatic logic [W-1:0] true_res(input logic [1:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [W-1:0] ref_res(input logic [1:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic inj);
      if (inj && a[0] && b[0]) return b;
      return true_res(op, a, b);
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // plan a DUT output 'lag' cycles from the current cycle
   task automatic resp(input int lag, input logic [W-1:0] val);
      plan[cyc + lag] = {1'b1, val};
   endtask

   task automatic step(input logic v, input logic [1:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic inj, input logic clr);
      logic         ev, dv, mis, ns;
      logic [W-1:0] e, d;
      int           nt, ne;
      ent_t         en;
      dv = 1'b0; d = '0; ev = 1'b0; e = '0;
      if (plan.exists(cyc)) begin
         dv = plan[cyc][W]; d = plan[cyc][W-1:0]; plan.delete(cyc);
      end
      if (sched.exists(cyc)) begin
         ev = sched[cyc][W]; e = sched[cyc][W-1:0]; sched.delete(cyc);
      end
      i_valid = v; i_op = op; i_a = a; i_b = b;
      i_inj_en = inj; i_clr = clr;
      i_dut_valid = dv;
      i_dut_o = dv ? d : W'($urandom);
      if (v) sched[cyc + LAT] = {1'b1, ref_res(op, a, b, inj)};
      nt = m_txn; ne = m_err; ns = m_sticky;
      if (ev || dv) begin
         mis = (ev && dv) ? (e != d) : 1'b1;
         if (ev) m_mon = e;
         if (dv) m_dtm = d;
         en = '{cyc + 1, mis, ev && !dv, dv && !ev, m_mon, m_dtm};
         sbq.push_back(en);
         if (!clr) begin
            nt = sat(nt + 1);
            if (mis) begin ne = sat(ne + 1); ns = 1'b1; end
         end
      end
      if (clr) begin nt = 0; ne = 0; ns = 1'b0; end
      @(posedge clk);
      cyc++;
      m_txn = nt; m_err = ne; m_sticky = ns;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_valid = 1'b0; i_dut_valid = 1'b0; i_clr = 1'b0;
      #1;
      chk("rst_cmp_valid", o_cmp_valid, 0);
      chk("rst_mismatch", o_mismatch, 0);
      chk("rst_missing", o_missing, 0);
      chk("rst_spurious", o_spurious, 0);
      chk("rst_mon_o", o_mon_o, 0);
      chk("rst_dtm_o", o_dtm_o, 0);
      chk("rst_txn_cnt", o_txn_cnt, 0);
      chk("rst_err_cnt", o_err_cnt, 0);
      chk("rst_sticky", o_sticky_err, 0);
      sched.delete(); plan.delete(); sbq.delete();
      m_txn = 0; m_err = 0; m_sticky = 1'b0; m_mon = '0; m_dtm = '0;
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      #1;
      reset = 1'b0;
   endtask

   // Monitor: counters every cycle, compare fields when one is due.
   always @(negedge clk) begin
      if (running && !reset) begin
         chk("txn_cnt", o_txn_cnt, m_txn);
         chk("err_cnt", o_err_cnt, m_err);
         chk("sticky_err", o_sticky_err, m_sticky);
         mon_ev = sbq.size() != 0 && sbq[0].due == cyc;
         chk("cmp_valid", o_cmp_valid, mon_ev);
         if (mon_ev) begin
            mon_en = sbq.pop_front();
            if (o_cmp_valid) begin
               chk("mismatch", o_mismatch, mon_en.mis);
               chk("missing", o_missing, mon_en.miss);
               chk("spurious", o_spurious, mon_en.spur);
               chk("mon_o", o_mon_o, mon_en.mon);
               chk("dtm_o", o_dtm_o, mon_en.dtm);
            end
         end else begin
            chk("idle_flags", {o_mismatch, o_missing, o_spurious}, 0);
         end
      end
   end

   initial begin
      logic [W-1:0] a, b;
      logic [1:0]   op;
      logic         v, inj;
      n_chk = 0; n_fail = 0; cyc = 0; running = 0;
      reset = 1'b0;
      i_valid = 0; i_op = 0; i_a = 0; i_b = 0; i_inj_en = 0;
      i_dut_valid = 0; i_dut_o = 0; i_clr = 0;
      #2;
      do_reset();
      running = 1;

      resp(LAT, 32'd12);
      step(1, 2'd0, 32'd5, 32'd7, 0, 0);
      idle(4);

      resp(LAT, 32'hFFFF_FFFF);
      step(1, 2'd1, 32'd0, 32'd1, 0, 0);
      resp(LAT, 32'h0000_F000);
      step(1, 2'd2, 32'hF0F0, 32'hFF00, 0, 0);
      resp(LAT, 32'h0000_0FF0);
      step(1, 2'd3, 32'hF0F0, 32'hFF00, 0, 0);
      idle(4);

      resp(LAT, 32'd8);
      step(1, 2'd0, 32'd3, 32'd5, 1, 0);
      idle(3);
      resp(LAT, 32'd8);
      step(1, 2'd0, 32'd3, 32'd5, 0, 0);
      idle(4);

      step(1, 2'd0, 32'd1, 32'd2, 0, 0);
      idle(4);
      resp(0, 32'h55);
      idle(4);

      step(0, 2'd0, '0, '0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom;
         resp(LAT, a + b);
         step(1, 2'd0, a, b, 0, 0);
      end
      idle(1);
      step(0, 2'd0, '0, '0, 0, 1);
      idle(3);
      chk("clr_txn_zero", o_txn_cnt, 0);
      chk("clr_sticky_zero", o_sticky_err, 0);

      for (int i = 0; i < 20; i++) begin
         resp(0, W'($urandom));
         idle(1);
      end
      idle(3);
      chk("sat_err_cnt", o_err_cnt, CMAX);

      step(1, 2'd0, 32'd9, 32'd9, 0, 0);
      step(1, 2'd1, 32'd9, 32'd4, 0, 0);
      do_reset();
      resp(0, 32'd7);
      idle(3);
      chk("post_rst_txn", o_txn_cnt, 1);

      step(0, 2'd0, '0, '0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom % 4) != 0;
         op  = 2'($urandom);
         a   = $urandom; b = $urandom;
         inj = 1'($urandom);
         if (v && ($urandom % 10) != 0)
            resp(LAT, true_res(op, a, b));
         else if (!v && ($urandom % 12) == 0 && !plan.exists(cyc))
            resp(0, W'($urandom));
         step(v, op, a, b, inj, ($urandom % 25) == 0);
      end
      idle(6);
      chk("sb_drained", sbq.size(), 0);

      running = 0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
